// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code sequencer.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK,
    PAUSE
  } state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] BAT       = 8'hAA;
  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] ECHO      = 8'hEE;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] OVR0      = 8'h00;
  localparam logic [7:0] OVR1      = 8'hFF;
  localparam int         PAUSE_LEN = 7;
  localparam int         KEY_IDX_W = 9;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  // Receiver overrun markers.
  function automatic logic is_ovr(input logic [7:0] b);
    return (b == OVR0) || (b == OVR1);
  endfunction

  // Keyboard-to-host protocol replies that carry no key information.
  function automatic logic is_proto(input logic [7:0] b);
    return (b == BAT) || (b == ACK) || (b == ECHO) || (b == RESEND);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Key-down bitmap indexed by {ext, code}; used to filter typematic repeats.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_IDX_W-1:0] idx,
  input  logic                 set,
  input  logic                 clr,
  output logic                 hit,
  output logic                 any_down
);

  logic [(1 << KEY_IDX_W)-1:0] map;

  assign hit      = map[idx];
  assign any_down = |map;

  // Set on an accepted make, clear on a break.
  // NOTE: this is a flop array, not a RAM, so it can and must be reset; a RAM macro could not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map <= '0;
    end else if (set) begin
      map[idx] <= 1'b1;
    end else if (clr) begin
      map[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 scan-code sequencer: drains receiver bytes, parses E0/F0/E1
// prefixes and emits one key event per complete sequence.
// Optional feature macro: PS2_KEYMAP_EN (typematic filter + any_down output).
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int TMR_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_rdy,
  input  logic [7:0] ps2_data,
  output logic       ps2_done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       err
`ifdef PS2_KEYMAP_EN
  ,
  output logic       any_down
`endif
);

  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [2:0]       skip, skip_nxt;
  logic [TMR_W-1:0] timer;
  event_t           ev_q, ev_nxt;
  logic             emit, emit_ok, ovr, is_pause;
  logic             pop, timeout;

  // A byte is only taken when the event slot is empty or being drained.
  assign ps2_done = ps2_rdy & (~ev_valid | ev_ready);
  assign pop      = ps2_done;
  // A pop in the expiry cycle keeps the sequence alive.
  assign timeout  = (state != IDLE) && (timer == TIMER_LAST) && !pop;

  assign ev_code = ev_q.code;
  assign ev_ext  = ev_q.ext;
  assign ev_brk  = ev_q.brk;

  // Decode the head byte against the current prefix state.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    emit      = 1'b0;
    ovr       = 1'b0;
    is_pause  = 1'b0;
    ev_nxt    = '{code: ps2_data, ext: 1'b0, brk: 1'b0};
    unique case (state)
      IDLE: begin
        if (ps2_data == PFX_EXT) begin
          state_nxt = EXT;
        end else if (ps2_data == PFX_BRK) begin
          state_nxt = BRK;
        end else if (ps2_data == PFX_PAUSE) begin
          state_nxt = PAUSE;
          skip_nxt  = 3'(PAUSE_LEN);
        end else if (is_ovr(ps2_data)) begin
          ovr = 1'b1;
        end else if (!is_proto(ps2_data)) begin
          emit = 1'b1;
        end
      end
      EXT: begin
        if (ps2_data == PFX_BRK) begin
          state_nxt = EXTBRK;
        end else begin
          state_nxt  = IDLE;
          ovr        = is_ovr(ps2_data);
          emit       = !is_ovr(ps2_data);
          ev_nxt.ext = 1'b1;
        end
      end
      BRK, EXTBRK: begin
        state_nxt  = IDLE;
        ovr        = is_ovr(ps2_data);
        emit       = !is_ovr(ps2_data);
        ev_nxt.ext = (state == EXTBRK);
        ev_nxt.brk = 1'b1;
      end
      PAUSE: begin
        if (skip == 3'd1) begin
          state_nxt = IDLE;
          emit      = 1'b1;
          is_pause  = 1'b1;
          ev_nxt    = '{code: PFX_PAUSE, ext: 1'b0, brk: 1'b0};
        end else begin
          skip_nxt = skip - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PS2_KEYMAP_EN
  logic key_hit;

  // Repeated makes of a held key are consumed silently; breaks always pass.
  assign emit_ok = emit & (is_pause | ev_nxt.brk | ~key_hit);

  ps2_key_map u_key_map (
    .clk      (clk),
    .rst      (rst),
    .idx      ({ev_nxt.ext, ev_nxt.code}),
    .set      (pop & emit_ok & ~is_pause & ~ev_nxt.brk),
    .clr      (pop & emit & ev_nxt.brk),
    .hit      (key_hit),
    .any_down (any_down)
  );
`else
  assign emit_ok = emit;
`endif

  // Sequencer state, inter-byte timer, error pulse and event output register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      skip     <= '0;
      timer    <= '0;
      err      <= 1'b0;
      ev_valid <= 1'b0;
      ev_q     <= '0;
    end else begin
      err <= (pop & ovr) | timeout;

      if (pop) begin
        state <= state_nxt;
        skip  <= skip_nxt;
        timer <= '0;
      end else if (timeout || state == IDLE) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (pop && emit_ok) begin
        ev_valid <= 1'b1;
        ev_q     <= ev_nxt;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a byte-queue FIFO feeds the DUT and a
// sequence-level parser predicts events, overrun/timeout errors and key map state.
module tb_ps2_kbd_ctrl;

  localparam int T = 40;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_rdy = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_done;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext, ev_brk, err;
`ifdef PS2_KEYMAP_EN
  logic       any_down;
`endif

  ps2_kbd_ctrl #(.TIMEOUT_CYC(T), .TMR_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_rdy  (ps2_rdy),
    .ps2_data (ps2_data),
    .ps2_done (ps2_done),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .err      (err)
`ifdef PS2_KEYMAP_EN
    ,
    .any_down (any_down)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] fifo[$];
  logic [9:0] exp_q[$];
  logic [7:0] seq[$];
  int         gap_cnt = 0;
  logic       err_pend = 1'b0;
  logic       new_ev = 1'b0;
  int         ready_mode = 0;
  bit [511:0] down = '0;
  logic       mon_pop, mon_err;
  logic [7:0] mon_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: record one expected key event, applying the typematic filter when enabled.
  task automatic emit(input logic [7:0] code, input logic ext, input logic brk, input logic pause);
`ifdef PS2_KEYMAP_EN
    if (!pause) begin
      if (brk) down[{ext, code}] = 1'b0;
      else if (down[{ext, code}]) return;
      else down[{ext, code}] = 1'b1;
    end
`endif
    exp_q.push_back({code, ext, brk});
    new_ev = 1'b1;
  endtask

  // Reference: Set-2 grammar applied to the bytes collected so far for this sequence.
  task automatic model_byte(input logic [7:0] b, output logic e);
    logic is_o;
    e    = 1'b0;
    is_o = (b == 8'h00) || (b == 8'hFF);
    if (seq.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) seq.push_back(b);
      else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) e = 1'b0;
      else if (is_o) e = 1'b1;
      else emit(b, 1'b0, 1'b0, 1'b0);
    end else if (seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) begin
        seq.delete();
        emit(8'hE1, 1'b0, 1'b0, 1'b1);
      end
    end else if (seq.size() == 1 && seq[0] == 8'hE0 && b == 8'hF0) begin
      seq.push_back(b);
    end else if (is_o) begin
      seq.delete();
      e = 1'b1;
    end else begin
      logic x, k;
      x = (seq[0] == 8'hE0);
      k = (seq[seq.size()-1] == 8'hF0);
      seq.delete();
      emit(b, x, k, 1'b0);
    end
  endtask

  // Drive the FIFO head and the consumer's ready just after each rising edge.
  always @(posedge clk) begin
    #1;
    ps2_rdy  = (fifo.size() != 0);
    ps2_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
    case (ready_mode)
      0:       ev_ready = 1'b1;
      1:       ev_ready = ($urandom_range(0, 3) != 0);
      default: ev_ready = 1'b0;
    endcase
  end

  // Compare DUT outputs with the reference on the falling edge, then advance the reference.
  always @(negedge clk) begin
    if (!rst) begin
      seq.delete();
      exp_q.delete();
      gap_cnt  = 0;
      err_pend = 1'b0;
      new_ev   = 1'b0;
      down     = '0;
    end else begin
      check("err", err, err_pend);
      if (new_ev) check("ev_latency", ev_valid, 1);
      if (ev_valid) begin
        if (exp_q.size() == 0) check("ev_spurious", ev_valid, 0);
        else begin
          check("ev", {ev_code, ev_ext, ev_brk}, exp_q[0]);
          if (ev_ready) void'(exp_q.pop_front());
        end
      end
`ifdef PS2_KEYMAP_EN
      check("any_down", any_down, |down);
`endif
      check("done", ps2_done, ps2_rdy & (~ev_valid | ev_ready));
      new_ev  = 1'b0;
      mon_err = 1'b0;
      mon_pop = ps2_rdy & ps2_done;
      if (mon_pop && fifo.size() != 0) begin
        mon_byte = fifo.pop_front();
        model_byte(mon_byte, mon_err);
        gap_cnt = 0;
      end else if (seq.size() != 0) begin
        gap_cnt++;
        if (gap_cnt == T) begin
          seq.delete();
          gap_cnt = 0;
          mon_err = 1'b1;
        end
      end
      err_pend = mon_err;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || ev_valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("drain_timeout", fifo.size() + exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    fifo.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_err", err, 0);
    check("rst_done", ps2_done, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    return 8'($urandom_range(8'h01, 8'h83));
  endfunction

  task automatic gen_seq();
    logic [7:0] c;
    c = rand_code();
    case ($urandom_range(0, 9))
      0, 1, 2: push(c);
      3: begin push(8'hF0); push(c); end
      4: begin push(8'hE0); push(c); end
      5: begin push(8'hE0); push(8'hF0); push(c); end
      6: begin
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
      end
      7: begin
        case ($urandom_range(0, 3))
          0: push(8'hAA);
          1: push(8'hFA);
          2: push(8'hEE);
          default: push(8'hFE);
        endcase
      end
      8: begin
        if ($urandom_range(0, 1) != 0) push(8'hE0);
        push(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      end
      default: begin
        push(($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0);
        push(8'($urandom_range(0, 255)));
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single make with a ready consumer.
    push(8'h1C);
    wait_drain();

    // Extended break and the Pause sequence.
    push(8'hE0); push(8'hF0); push(8'h74);
    wait_drain();
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    wait_drain();

    // Consumer stall with bytes queued behind a held event.
    ready_mode = 2;
    repeat (2) @(negedge clk);
    push(8'h1B); push(8'h23); push(8'h2B); push(8'h34);
    repeat (12) @(negedge clk);
    check("stall_done", ps2_done, 0);
    check("stall_fifo", fifo.size(), 3);
    check("stall_valid", ev_valid, 1);
    ready_mode = 0;
    wait_drain();

    // Stalled break prefix times out, then a normal make.
    push(8'hF0);
    repeat (T + 6) @(negedge clk);
    push(8'h1C);
    wait_drain();

    // Overrun byte.
    push(8'hFF);
    wait_drain();

    // Reset in the middle of an extended prefix.
    push(8'hE0);
    repeat (4) @(negedge clk);
    do_reset();
    push(8'h1C);
    wait_drain();

`ifdef PS2_KEYMAP_EN
    // Typematic repeat filtering.
    push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_drain();
`endif

    // Randomised traffic with a bursty consumer and occasional stalled prefixes.
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      gen_seq();
      if ($urandom_range(0, 3) == 0) wait_drain();
      if (i % 40 == 39) begin
        wait_drain();
        push(($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hE1);
        repeat (T + 4) @(negedge clk);
      end
    end
    wait_drain();
    ready_mode = 0;
    wait_drain();
    check("leftover_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
